// File: rtl/mor1kx_bpred_pkg.sv
// ---------------------------------------------------------------------------
// mor1kx_bpred_pkg
// Shared definitions for the gshare branch predictor:
//   - 2-bit saturating counter encodings
//   - PHT controller FSM state encoding
//   - sat_update(): saturating increment/decrement of a counter
// ---------------------------------------------------------------------------
package mor1kx_bpred_pkg;

    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } pht_state_e;

    // Move a counter one step toward the actual outcome, clamped at 0 and 3.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt,
                                              input logic       taken);
        if (taken)
            return (cnt == STRONGLY_TAKEN) ? cnt : cnt + 2'd1;
        else
            return (cnt == STRONGLY_NOT_TAKEN) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/mor1kx_bpred_pht_ctrl_if.sv
// ---------------------------------------------------------------------------
// mor1kx_bpred_pht_ctrl_if
// Bundles the decode lookup, resolve update and PHT RAM port signals of the
// PHT controller.
//   slave  : the controller side (mor1kx_bpred_pht_ctrl)
//   master : the pipeline + RAM side driving lookups/updates and read data
// ---------------------------------------------------------------------------
interface mor1kx_bpred_pht_ctrl_if #(
    parameter int GSHARE_BITS_NUM = 10
);
    logic                       lookup_valid_i;
    logic [GSHARE_BITS_NUM-1:0] lookup_idx_i;
    logic                       pred_valid_o;
    logic                       pred_taken_o;
    logic                       update_valid_i;
    logic [GSHARE_BITS_NUM-1:0] update_idx_i;
    logic                       update_taken_i;
    logic                       update_ready_o;
    logic                       update_drop_o;
    logic                       init_busy_o;
    logic [GSHARE_BITS_NUM-1:0] ram_addr_o;
    logic                       ram_we_o;
    logic [1:0]                 ram_wdata_o;
    logic [1:0]                 ram_rdata_i;

    modport slave (
        input  lookup_valid_i, lookup_idx_i,
        input  update_valid_i, update_idx_i, update_taken_i,
        input  ram_rdata_i,
        output pred_valid_o, pred_taken_o,
        output update_ready_o, update_drop_o, init_busy_o,
        output ram_addr_o, ram_we_o, ram_wdata_o
    );

    modport master (
        output lookup_valid_i, lookup_idx_i,
        output update_valid_i, update_idx_i, update_taken_i,
        output ram_rdata_i,
        input  pred_valid_o, pred_taken_o,
        input  update_ready_o, update_drop_o, init_busy_o,
        input  ram_addr_o, ram_we_o, ram_wdata_o
    );
endinterface

// File: rtl/mor1kx_bpred_upd_fifo.sv
// ---------------------------------------------------------------------------
// mor1kx_bpred_upd_fifo
// Synchronous FIFO holding pending counter updates.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i; accepted when not full, or when full with a
//               simultaneous pop (the pop frees the slot)
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status from the registered count
// ---------------------------------------------------------------------------
module mor1kx_bpred_upd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (count_o == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and
    // pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/mor1kx_bpred_pht_ctrl.sv
// ---------------------------------------------------------------------------
// mor1kx_bpred_pht_ctrl
// Owns the single-port synchronous-read PHT RAM of the gshare predictor.
// After reset it sweeps every entry to INIT_STATE, then serves decode
// lookups with absolute port priority and applies queued resolve updates
// as read-modify-write sequences in the gaps.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lookup (lookup_*/pred_*), update (update_*), status
//              (init_busy_o) and RAM port (ram_*) signals
// ---------------------------------------------------------------------------
module mor1kx_bpred_pht_ctrl
    import mor1kx_bpred_pkg::*;
#(
    parameter int         GSHARE_BITS_NUM = 10,
    parameter int         UPD_FIFO_DEPTH  = 2,
    parameter logic [1:0] INIT_STATE      = WEAKLY_TAKEN
) (
    input  logic                   clk,
    input  logic                   rst,
    mor1kx_bpred_pht_ctrl_if.slave bus
);
    localparam int GB = GSHARE_BITS_NUM;
    localparam int CW = $clog2(UPD_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(UPD_FIFO_DEPTH);

    pht_state_e    state_q, state_d;
    logic [GB:0]   ptr_q, ptr_d;     // extra MSB flags the end of the sweep
    logic [1:0]    hold_q, hold_d;
    logic          pred_valid_q;
    logic          pred_ram_q;       // prediction comes from RAM, not INIT_STATE
    logic          drop_q;

    logic [GB:0]   fifo_head;
    logic [GB-1:0] head_idx;
    logic          head_taken;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    logic [GB-1:0] ram_addr;
    logic          ram_we;
    logic [1:0]    ram_wdata;

    assign head_idx   = fifo_head[GB:1];
    assign head_taken = fifo_head[0];

    mor1kx_bpred_upd_fifo #(
        .WIDTH (GB + 1),
        .DEPTH (UPD_FIFO_DEPTH)
    ) u_upd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.update_valid_i),
        .pop_i   (pop),
        .wdata_i ({bus.update_idx_i, bus.update_taken_i}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        ram_addr  = bus.lookup_idx_i;
        ram_we    = 1'b0;
        ram_wdata = hold_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                ram_addr  = ptr_q[GB-1:0];
                ram_we    = 1'b1;
                ram_wdata = INIT_STATE;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_d[GB]) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.lookup_valid_i && !fifo_empty) begin
                    ram_addr = head_idx;
                    state_d  = ST_UPD_RD;
                end
            end
            ST_UPD_RD: begin
                // Read data belongs to the head read issued last cycle; a
                // lookup now only uses the port for its own read.
                hold_d  = sat_update(bus.ram_rdata_i, head_taken);
                state_d = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                if (!bus.lookup_valid_i) begin
                    ram_addr = head_idx;
                    ram_we   = 1'b1;
                    pop      = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            hold_q       <= STRONGLY_NOT_TAKEN;
            pred_valid_q <= 1'b0;
            pred_ram_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            pred_valid_q <= bus.lookup_valid_i;
            pred_ram_q   <= (state_q != ST_INIT);
            drop_q       <= bus.update_valid_i && fifo_full && !pop;
        end
    end

    assign bus.pred_valid_o   = pred_valid_q;
    assign bus.pred_taken_o   = pred_ram_q ? bus.ram_rdata_i[1] : INIT_STATE[1];
    assign bus.update_ready_o = (fifo_count != FULL_CNT);
    assign bus.update_drop_o  = drop_q;
    assign bus.init_busy_o    = (state_q == ST_INIT);
    assign bus.ram_addr_o     = ram_addr;
    assign bus.ram_we_o       = ram_we && !rst;   // no stray write while in reset
    assign bus.ram_wdata_o    = ram_wdata;

endmodule

// File: tb/tb_mor1kx_bpred_pht_ctrl.sv
module tb_mor1kx_bpred_pht_ctrl;
    localparam int GB      = 4;
    localparam int ENTRIES = 1 << GB;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mor1kx_bpred_pht_ctrl_if #(.GSHARE_BITS_NUM(GB)) ifc ();

    mor1kx_bpred_pht_ctrl #(
        .GSHARE_BITS_NUM (GB),
        .UPD_FIFO_DEPTH  (DEPTH),
        .INIT_STATE      (2'b10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Behavioural single-port synchronous-read RAM.
    logic [1:0] mem [ENTRIES];
    logic [1:0] ram_rdata = 2'b00;
    always @(posedge clk) begin
        if (ifc.ram_we_o) mem[ifc.ram_addr_o] <= ifc.ram_wdata_o;
        else              ram_rdata <= mem[ifc.ram_addr_o];
    end
    assign ifc.ram_rdata_i = ram_rdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        int taken;
    } upd_t;

    upd_t q[$];
    int   ref_tbl [ENTRIES];
    int   init_cnt = 0;
    int   exp_pred_valid = 0;
    int   exp_pred_taken = 0;
    int   exp_drop = 0;

    function automatic int step_counter(input int v, input int taken);
        if (taken != 0) return (v >= 3) ? 3 : v + 1;
        else            return (v <= 0) ? 0 : v - 1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_we", int'(ifc.ram_we_o), 0);
            check("rst_busy", int'(ifc.init_busy_o), 1);
            check("rst_pred_valid", int'(ifc.pred_valid_o), 0);
            check("rst_drop", int'(ifc.update_drop_o), 0);
            q.delete();
            for (int i = 0; i < ENTRIES; i++) ref_tbl[i] = 2;
            init_cnt       = 0;
            exp_pred_valid = 0;
            exp_drop       = 0;
        end else begin
            bit in_init;
            bit pop;
            in_init = (init_cnt < ENTRIES);
            pop     = 1'b0;

            check("pred_valid", int'(ifc.pred_valid_o), exp_pred_valid);
            if (exp_pred_valid != 0)
                check("pred_taken", int'(ifc.pred_taken_o), exp_pred_taken);
            check("drop", int'(ifc.update_drop_o), exp_drop);
            check("init_busy", int'(ifc.init_busy_o), int'(in_init));
            check("update_ready", int'(ifc.update_ready_o), int'(q.size() < DEPTH));

            if (in_init) begin
                check("init_we", int'(ifc.ram_we_o), 1);
                check("init_addr", int'(ifc.ram_addr_o), init_cnt);
                check("init_wdata", int'(ifc.ram_wdata_o), 2);
            end else if (ifc.lookup_valid_i) begin
                check("lookup_we", int'(ifc.ram_we_o), 0);
                check("lookup_addr", int'(ifc.ram_addr_o), int'(ifc.lookup_idx_i));
            end else if (ifc.ram_we_o) begin
                check("wr_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    int nv;
                    nv = step_counter(ref_tbl[q[0].idx], q[0].taken);
                    check("wr_addr", int'(ifc.ram_addr_o), q[0].idx);
                    check("wr_data", int'(ifc.ram_wdata_o), nv);
                    ref_tbl[q[0].idx] = nv;
                    pop = 1'b1;
                end
            end

            exp_pred_valid = int'(ifc.lookup_valid_i);
            exp_pred_taken = in_init ? 1 : (ref_tbl[ifc.lookup_idx_i] >> 1);
            exp_drop = int'(ifc.update_valid_i && (q.size() == DEPTH) && !pop);
            if (pop) void'(q.pop_front());
            if (ifc.update_valid_i && (q.size() < DEPTH))
                q.push_back('{idx: int'(ifc.update_idx_i), taken: int'(ifc.update_taken_i)});
            if (in_init) init_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit lv, input int li, input bit uv, input int ui, input bit ut);
        ifc.lookup_valid_i = lv;
        ifc.lookup_idx_i   = GB'(li);
        ifc.update_valid_i = uv;
        ifc.update_idx_i   = GB'(ui);
        ifc.update_taken_i = ut;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_update(input int idx, input bit taken);
        cyc(0, 0, 1, idx, taken);
        idle(4);
    endtask

    initial begin
        ifc.lookup_valid_i = 1'b0;
        ifc.lookup_idx_i   = '0;
        ifc.update_valid_i = 1'b0;
        ifc.update_idx_i   = '0;
        ifc.update_taken_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Init sweep, then quiet port with idle inputs.
        idle(ENTRIES + 4);
        begin
            int bad = 0;
            for (int i = 0; i < ENTRIES; i++) if (mem[i] != 2'b10) bad++;
            check("init_all_weakly_taken", bad, 0);
        end

        // Lookup after init.
        cyc(1, 5, 0, 0, 0);
        ifc.lookup_valid_i = 1'b0;
        @(negedge clk);
        check("lit_pred_valid_idx5", int'(ifc.pred_valid_o), 1);
        check("lit_pred_taken_idx5", int'(ifc.pred_taken_o), 1);
        @(posedge clk); #1;

        // Saturation up then down.
        repeat (3) do_update(5, 1'b1);
        check("lit_idx5_sat_hi", int'(mem[5]), 3);
        check("lit_model_idx5_hi", ref_tbl[5], 3);
        repeat (4) do_update(5, 1'b0);
        check("lit_idx5_sat_lo", int'(mem[5]), 0);
        cyc(1, 5, 0, 0, 0);
        ifc.lookup_valid_i = 1'b0;
        @(negedge clk);
        check("lit_pred_taken_idx5_lo", int'(ifc.pred_taken_o), 0);
        @(posedge clk); #1;

        // Lookup defers the read.
        cyc(0, 0, 1, 3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1, i, 0, 0, 0);
        idle(5);
        check("lit_idx3_deferred", int'(mem[3]), 3);

        // Lookups stall the write in UPD_WR.
        cyc(0, 0, 1, 9, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(1, 9, 0, 0, 0);
        idle(5);
        check("lit_idx9_stalled", int'(mem[9]), 1);

        // Queue fills under continuous lookups; third update dropped.
        cyc(1, 1, 1, 7, 1'b1);
        cyc(1, 2, 1, 8, 1'b0);
        ifc.lookup_valid_i = 1'b1;
        ifc.update_valid_i = 1'b1;
        ifc.update_idx_i   = 4'd10;
        ifc.update_taken_i = 1'b1;
        @(negedge clk);
        check("lit_ready_full", int'(ifc.update_ready_o), 0);
        @(posedge clk); #1;
        ifc.update_valid_i = 1'b0;
        @(negedge clk);
        check("lit_drop_pulse", int'(ifc.update_drop_o), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc(1, 4, 0, 0, 0);
        idle(10);
        check("lit_idx7", int'(mem[7]), 3);
        check("lit_idx8", int'(mem[8]), 1);
        check("lit_idx10_dropped", int'(mem[10]), 2);

        // Reset mid-sweep at ptr 7 with a queued update pending.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        cyc(0, 0, 1, 1, 1'b1);
        idle(4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        cyc(0, 0, 1, 2, 1'b1);
        cyc(1, 4, 0, 0, 0);
        idle(11);
        @(negedge clk);
        check("lit_busy_cycle15", int'(ifc.init_busy_o), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("lit_busy_cycle16", int'(ifc.init_busy_o), 0);
        @(posedge clk); #1;
        idle(10);
        check("lit_idx2_after_init", int'(mem[2]), 3);
        check("lit_idx1_discarded", int'(mem[1]), 2);

        check("queue_drained", q.size(), 0);
        begin
            int bad = 0;
            for (int i = 0; i < ENTRIES; i++) if (int'(mem[i]) != ref_tbl[i]) bad++;
            check("final_table", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
